// File: rtl/axis_step_executor.sv
// axis_step_executor
//   Turns one latched timing parameter set {N, nn, t0, tna, delta} into a
//   STEP/DIR pulse train with a trapezoidal period profile
//   (accelerate / cruise / decelerate). One instance per axis.
//
// Parameters:
//   PULSE_W     STEP high time in clk cycles (>= 1)
//   MIN_PERIOD  lower clamp on every step period (>= 2*PULSE_W)
//   ENDSTOP_DIR direction in which the endstop aborts (only with the macro)
//
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   start       level handshake; held high for the whole move
//   num         signed step count, sign selects dir only
//   params      0:N 1:nn 2:t0 3:tna 4:delta
//   step        step pulse to the driver
//   dir         1 when num >= 0
//   busy        high while stepping (ACCEL/CRUISE/DECEL)
//   step_cnt    steps issued in the current move
//   finish      high in DONE, held until start drops
//   endstop/hit only when STEP_EXEC_ENDSTOP_EN is defined: endstop input
//               aborts the move, hit flags the abort until the IDLE return
module axis_step_executor #(
  parameter int unsigned PULSE_W    = 10,
  parameter int unsigned MIN_PERIOD = 20
`ifdef STEP_EXEC_ENDSTOP_EN
  , parameter logic      ENDSTOP_DIR = 1'b0
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] num,
  input  logic        [31:0] params [0:4],
  output logic               step,
  output logic               dir,
  output logic               busy,
  output logic        [31:0] step_cnt,
  output logic               finish
`ifdef STEP_EXEC_ENDSTOP_EN
  , input  logic             endstop,
  output logic               hit
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACCEL, S_CRUISE, S_DECEL, S_DONE
  } state_t;

  localparam logic [31:0] PW    = 32'(PULSE_W);
  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);

  state_t      state_q, state_d;
  logic        step_q, step_d, dir_q, dir_d, busy_q, busy_d, finish_q, finish_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic [31:0] ph_q, ph_d;              // cycle index inside the current period
  logic [31:0] n_q, n_d, nn_eff_q, nn_eff_d, tna_q, tna_d, delta_q, delta_d;
  logic [31:0] raw_q, raw_d;            // unclamped period of the current step
  logic [31:0] cap_q, cap_d;            // max(t0, tna)
  logic [31:0] acc_last_q, acc_last_d;  // last accel period, first decel period
`ifdef STEP_EXEC_ENDSTOP_EN
  logic        hit_q, hit_d, abort_pend_q, abort_pend_d, es_match;
`endif

  logic [31:0] period, cnt_nxt, dec_raw, inc_raw, half_n;
  logic        last;

  always_comb begin
    period  = (raw_q > MIN_P) ? raw_q : MIN_P;
    last    = (ph_q == period - 32'd1);
    cnt_nxt = step_cnt_q + 32'd1;
    half_n  = n_q >> 1;
    // raw stays within [tna, cap], so both differences are non-negative
    dec_raw = ((raw_q - tna_q) >= delta_q) ? raw_q - delta_q : tna_q;
    inc_raw = ((cap_q - raw_q) >= delta_q) ? raw_q + delta_q : cap_q;
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    dir_d      = dir_q;
    busy_d     = busy_q;
    finish_d   = finish_q;
    step_cnt_d = step_cnt_q;
    ph_d       = ph_q;
    n_d        = n_q;
    nn_eff_d   = nn_eff_q;
    tna_d      = tna_q;
    delta_d    = delta_q;
    raw_d      = raw_q;
    cap_d      = cap_q;
    acc_last_d = acc_last_q;
`ifdef STEP_EXEC_ENDSTOP_EN
    hit_d        = hit_q;
    abort_pend_d = abort_pend_q;
    es_match     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d      = params[0];
          nn_eff_d = (params[1] < (params[0] >> 1)) ? params[1] : (params[0] >> 1);
          tna_d    = params[3];
          delta_d  = params[4];
          raw_d    = (params[2] > params[3]) ? params[2] : params[3];
          cap_d    = (params[2] > params[3]) ? params[2] : params[3];
          dir_d    = ~num[31];
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        ph_d = '0;
        if (n_q == '0) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end else begin
          busy_d = 1'b1;
          step_d = 1'b1;
          if (nn_eff_q == '0) begin
            state_d = S_CRUISE;
            raw_d   = tna_q;
          end else begin
            state_d = S_ACCEL;
          end
        end
      end
      S_ACCEL, S_CRUISE, S_DECEL: begin
        if (last) begin
          step_cnt_d = cnt_nxt;
          ph_d       = '0;
          step_d     = 1'b1;
          case (state_q)
            S_ACCEL: begin
              if (cnt_nxt == nn_eff_q) begin
                if ((n_q - (nn_eff_q << 1)) != '0) begin
                  state_d    = S_CRUISE;
                  acc_last_d = raw_q;
                  // odd N with accel covering half: lone middle step continues
                  // the accel ramp instead of jumping to the cruise period
                  raw_d      = (nn_eff_q == half_n) ? dec_raw : tna_q;
                end else begin
                  state_d = S_DECEL;  // first decel step repeats last accel period
                end
              end else begin
                raw_d = dec_raw;
              end
            end
            S_CRUISE: begin
              if (cnt_nxt == n_q) begin
                state_d = S_DONE;
              end else if ((nn_eff_q != '0) && (cnt_nxt == n_q - nn_eff_q)) begin
                state_d = S_DECEL;
                raw_d   = acc_last_q;
              end
            end
            default: begin
              if (cnt_nxt == n_q) state_d = S_DONE;
              else                raw_d   = inc_raw;
            end
          endcase
          if (state_d == S_DONE) begin
            step_d   = 1'b0;
            busy_d   = 1'b0;
            finish_d = 1'b1;
          end
        end else begin
          ph_d   = ph_q + 32'd1;
          step_d = ((ph_q + 32'd1) < PW);
        end
`ifdef STEP_EXEC_ENDSTOP_EN
        // abort only once the current pulse has served its full high time
        es_match = endstop && (dir_q == ENDSTOP_DIR);
        if (es_match) abort_pend_d = 1'b1;
        if ((abort_pend_q || es_match) && (ph_q >= PW - 32'd1)) begin
          state_d      = S_DONE;
          step_d       = 1'b0;
          busy_d       = 1'b0;
          finish_d     = 1'b1;
          hit_d        = 1'b1;
          abort_pend_d = 1'b0;
          step_cnt_d   = cnt_nxt;
        end
`endif
      end
      S_DONE: begin
        if (!start) begin
          state_d    = S_IDLE;
          finish_d   = 1'b0;
          step_cnt_d = '0;
`ifdef STEP_EXEC_ENDSTOP_EN
          hit_d        = 1'b0;
          abort_pend_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      step_cnt_q <= '0;
      ph_q       <= '0;
      n_q        <= '0;
      nn_eff_q   <= '0;
      tna_q      <= '0;
      delta_q    <= '0;
      raw_q      <= '0;
      cap_q      <= '0;
      acc_last_q <= '0;
`ifdef STEP_EXEC_ENDSTOP_EN
      hit_q        <= 1'b0;
      abort_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
      step_cnt_q <= step_cnt_d;
      ph_q       <= ph_d;
      n_q        <= n_d;
      nn_eff_q   <= nn_eff_d;
      tna_q      <= tna_d;
      delta_q    <= delta_d;
      raw_q      <= raw_d;
      cap_q      <= cap_d;
      acc_last_q <= acc_last_d;
`ifdef STEP_EXEC_ENDSTOP_EN
      hit_q        <= hit_d;
      abort_pend_q <= abort_pend_d;
`endif
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign busy     = busy_q;
  assign step_cnt = step_cnt_q;
  assign finish   = finish_q;
`ifdef STEP_EXEC_ENDSTOP_EN
  assign hit      = hit_q;
`endif

endmodule

// File: tb/tb_axis_step_executor.sv
// Directed bench for axis_step_executor: expected step periods are pushed to
// a queue when a move is launched and popped as each period is observed.
module tb_axis_step_executor;

  localparam int PULSE_W    = 10;
  localparam int MIN_PERIOD = 20;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic signed [31:0] num = '0;
  logic        [31:0] params [0:4];
  logic               step, dir, busy, finish;
  logic        [31:0] step_cnt;
`ifdef STEP_EXEC_ENDSTOP_EN
  logic               endstop = 1'b0;
  logic               hit;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  longint exp_q [$];

  always #5 clk = ~clk;

  axis_step_executor #(.PULSE_W(PULSE_W), .MIN_PERIOD(MIN_PERIOD)) dut (
    .clk(clk), .reset(reset), .start(start), .num(num), .params(params),
    .step(step), .dir(dir), .busy(busy), .step_cnt(step_cnt), .finish(finish)
`ifdef STEP_EXEC_ENDSTOP_EN
    , .endstop(endstop), .hit(hit)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Closed-form profile: P_k = max(t0 - j*delta, tna) clamped to MIN_PERIOD
  function automatic longint exp_period(input int k, input int n, input int nne,
                                        input int t0, input int tna, input int delta);
    longint j, base;
    if (k < nne)                                   j = k;
    else if (k >= n - nne)                         j = n - 1 - k;
    else if ((n % 2 == 1) && nne == n / 2 && nne > 0) j = k;
    else                                           j = -1;
    if (j < 0) base = tna;
    else begin
      base = longint'(t0) - j * longint'(delta);
      if (base < tna) base = tna;
    end
    if (base < MIN_PERIOD) base = MIN_PERIOD;
    return base;
  endfunction

  // mode 0: run to finish; 1: stop watching at rise number 'mark' (caller resets);
  // 2: raise endstop at rise number 'mark'
  task automatic run_move(input int n, input int nn, input int t0, input int tna,
                          input int delta, input int numv, input int mode, input int mark);
    longint sum = 0;
    int nne, cyc, rises, last_rise, budget;
    logic prev;
    bit done, stopped;
    nne = (nn < n / 2) ? nn : n / 2;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(exp_period(k, n, nne, t0, tna, delta));
      sum += exp_period(k, n, nne, t0, tna, delta);
    end
    num = numv;
    params[0] = n; params[1] = nn; params[2] = t0; params[3] = tna; params[4] = delta;
    start = 1'b1;
    cyc = 0; rises = 0; last_rise = 0; prev = 1'b0; done = 0; stopped = 0;
    budget = int'(sum) * 2 + 100;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (step && !prev) begin
        if (rises == 0) begin
          check("first_rise_latency", cyc, 2);
          check("busy_in_move", {31'd0, busy}, 1);
          check("dir", {31'd0, dir}, {31'd0, numv >= 0});
        end else if (!stopped && exp_q.size() > 0) begin
          check("period", cyc - last_rise, 32'(exp_q.pop_front()));
        end
        rises++;
        last_rise = cyc;
        if (mode == 1 && rises == mark) done = 1;
`ifdef STEP_EXEC_ENDSTOP_EN
        if (mode == 2 && rises == mark) begin
          endstop = 1'b1;
          stopped = 1;
        end
`endif
      end
      if (!step && prev) check("high_width", cyc - last_rise, PULSE_W);
      prev = step;
      if (finish && mode != 1) done = 1;
    end
    if (mode == 1) begin
      check("reached_abort_point", rises, mark);
    end else begin
      check("finish_seen", {31'd0, finish}, 1);
      check("busy_at_finish", {31'd0, busy}, 0);
      check("step_low_at_finish", {31'd0, step}, 0);
      check("dir_at_finish", {31'd0, dir}, {31'd0, numv >= 0});
      if (mode == 0) begin
        if (rises > 0 && exp_q.size() > 0)
          check("period_last", cyc - last_rise, 32'(exp_q.pop_front()));
        check("total_cycles", cyc - 2, 32'(sum));
        check("pulse_count", rises, n);
        check("step_cnt", step_cnt, n);
        check("queue_empty", exp_q.size(), 0);
      end
    end
  endtask

  task automatic end_move();
    start = 1'b0;
    @(negedge clk);
    check("finish_cleared", {31'd0, finish}, 0);
    check("step_cnt_cleared", step_cnt, 0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) params[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_step", {31'd0, step}, 0);
    check("rst_dir", {31'd0, dir}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_finish", {31'd0, finish}, 0);
    check("rst_step_cnt", step_cnt, 0);
    reset = 1'b0;
    @(negedge clk);

    // N=0: finish two cycles after start with no pulses
    run_move(0, 0, 100, 40, 20, 0, 0, 0);
    end_move();

    // full trapezoid: 100,80,60,40,40,40,40,60,80,100
    run_move(10, 3, 100, 40, 20, 10, 0, 0);
    end_move();

    // nn clipped to N>>1, odd N middle step: 50,40,30,40,50
    run_move(5, 4, 50, 30, 10, -5, 0, 0);
    end_move();

    // every period clamped up to MIN_PERIOD
    run_move(3, 1, 10, 10, 5, 3, 0, 0);
    end_move();

    // delta=0: flat at max(t0,tna)
    run_move(4, 2, 60, 40, 0, 4, 0, 0);
    end_move();

    // tna > t0: flat at tna
    run_move(3, 1, 30, 50, 10, -3, 0, 0);
    end_move();

    // no accel phase: pure cruise
    run_move(3, 0, 90, 25, 10, 3, 0, 0);
    end_move();

    // reset in the middle of the 4th step, then replay the full profile
    run_move(10, 3, 100, 40, 20, 10, 1, 4);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("mid_rst_step", {31'd0, step}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_step_cnt", step_cnt, 0);
    check("mid_rst_finish", {31'd0, finish}, 0);
    reset = 1'b0;
    @(negedge clk);
    run_move(10, 3, 100, 40, 20, 10, 0, 0);
    end_move();

`ifdef STEP_EXEC_ENDSTOP_EN
    // endstop during cruise in the abort direction
    run_move(10, 3, 100, 40, 20, -10, 2, 5);
    check("hit_set", {31'd0, hit}, 1);
    check("aborted_short", {31'd0, step_cnt < 32'd10}, 1);
    endstop = 1'b0;
    end_move();
    check("hit_cleared", {31'd0, hit}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
